main_mem_responder: RTL and testbench
=====================================

// Module: main_mem_responder
// PURPOSE
//  Main-memory responder on the far side of the cache miss handler.
//  Serves single-word reads, single-word write-through writes, and 8-word block-fill bursts.
//  It has a fixed, fully pipelined read latency and is the backing store for both I- and D-caches.
//  It holds no caching state of its own: it is the storage end of the miss/fill interface.
// PARAMETERS
//  LATENCY      4    cycles from request accept to first resp_valid (>=1)
//  BLOCK_WORDS  8    words returned per burst (power of 2)
//  MEM_WORDS    32768  16-bit words of storage (byte address bits [15:1])
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   request present this cycle
//  req_ready  out  1   responder can accept; a request is accepted when req_valid & req_ready
//  req_wr     in   1   1 = write word, 0 = read
//  req_burst  in   1   with req_wr=0: block fill of BLOCK_WORDS words (ignored on writes)
//  req_addr   in   16  byte address; bit 0 ignored
//  req_wdata  in   16  write data
//  resp_valid out  1   resp_data/resp_addr valid this cycle
//  resp_data  out  16  read data
//  resp_addr  out  16  byte address of resp_data (bit 0 = 0); lets the miss handler place words
// BEHAVIOUR
//  Reset
//   - req_ready=1, resp_valid=0, resp_data=0, resp_addr=0, FSM=IDLE.
//   - All pipeline valid bits are cleared; memory contents are untouched.
//  FSM IDLE
//   - Accepted write: the word is written to mem[req_addr[15:1]] at that edge. No response.
//   - Accepted single read: the read enters the LATENCY-stage pipe. resp_valid is asserted
//     exactly LATENCY cycles after the accept edge.
//   - Accepted burst read: base = {req_addr[15:4],4'b0} (block-aligned; offset bits ignored).
//     The base word issues in the accept cycle. Go to BURST with cnt=1.
//  FSM BURST
//   - req_ready=0. One internal read issues per cycle at base+2*cnt. cnt increments.
//   - When cnt==BLOCK_WORDS-1 issues, return to IDLE. req_ready=1 on the following cycle.
//   - Responses: BLOCK_WORDS consecutive resp_valid cycles in ascending address order.
//     The first response comes LATENCY cycles after accept.
//   - The burst never crosses its block. Block 0xFFF0 ends at 0xFFFE, with no wrap past 0xFFFF.
//  Throughput and ordering
//   - In IDLE, single reads/writes are accepted every cycle with no bubbles.
//   - Responses return in issue order.
//  Hazards
//   - A read accepted the cycle after a write to the same word returns the new data.
//     The array read happens at issue, after the write edge.
//   - Reads already in the pipe are not altered by later writes.
//  Boundary cases
//   - req_valid while req_ready=0: the request is not accepted. The requester must hold it.
//   - Reset mid-burst or with reads in flight: everything in flight is dropped. The cycle after
//     rst, resp_valid=0 and FSM=IDLE.
//   - req_burst=1 with req_wr=1: treated as a single write.
//  Width rules
//   - Address arithmetic is 16-bit unsigned.
//   - Word index = addr[15:1]; indices >= MEM_WORDS alias modulo MEM_WORDS.
// STRUCTURE
//  - Shared include mem_defs.vh: BLOCK_WORDS, LATENCY defaults, FSM state encodings
//    (ST_IDLE=1'b0, ST_BURST=1'b1).
//  - Sub-module mem_word_array: single-port MEM_WORDS x 16 array with combinational read and
//    synchronous write.
//  - The top level holds the FSM, the burst counter, and a LATENCY-deep shift register of
//    {valid, addr, data}. Built from existing dff cells.
// TESTING
//  - Reset: hold rst 2 cycles -> resp_valid=0, req_ready=1, no response for 2*LATENCY cycles.
//  - Write then read: write 0x1234 @0x0040 at cycle 0, read @0x0040 at cycle 1
//    -> resp_valid at cycle 5 with data 0x1234, resp_addr 0x0040.
//  - Burst: preload 0x0100..0x010E with 0xA0..0xA7, burst @0x0106 at cycle 0
//    -> req_ready=0 cycles 1-7; resp_valid cycles 4-11; addrs 0x0100..0x010E; data 0xA0..0xA7.
//  - Back-to-back: 4 single reads on cycles 0-3 -> 4 responses on cycles 4-7, in order.
//    No stall.
//  - Top block: burst @0xFFF2 -> last resp_addr 0xFFFE; no response at 0x0000.
//  - Reset mid-burst: assert rst at cycle 5 of a burst -> resp_valid=0 from cycle 6.
//    A new single read at cycle 7 -> response at cycle 11 only.

Source files
------------

// File: rtl/main_mem_responder_pkg.sv
// Shared constants, FSM encodings and the response pipe entry for main_mem_responder.
package main_mem_responder_pkg;

  localparam int unsigned LATENCY_DEF     = 4;
  localparam int unsigned BLOCK_WORDS_DEF = 8;
  localparam int unsigned MEM_WORDS_DEF   = 32768;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic [15:0] data;
  } pipe_ent_t;

  // Block-aligned base: clears the word-offset bits and the ignored byte bit.
  function automatic logic [15:0] block_base(input logic [15:0] addr,
                                             input int unsigned block_words);
    logic [15:0] blk_bytes;
    blk_bytes = 16'(2 * block_words);
    return addr & ~(blk_bytes - 16'd1);
  endfunction

endpackage

// File: rtl/main_mem_responder_mem_word_array.sv
// Single-port 16-bit word store: combinational read, write on the rising edge.
module mem_word_array #(
  parameter int unsigned WORDS = 32768,
  parameter int unsigned AW    = 15
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [15:0]   rd_data
);

  logic [15:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/main_mem_responder.sv
// Backing-store responder: single reads/writes and block-fill bursts with a fixed read latency.
// state | meaning: ST_IDLE accept requests / ST_BURST issue remaining block words, req_ready=0
module main_mem_responder
  import main_mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY     = LATENCY_DEF,
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int unsigned MEM_WORDS   = MEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_burst,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [15:0] resp_addr
);

  localparam int unsigned CW = $clog2(BLOCK_WORDS);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   base_q, base_d;
  pipe_ent_t     pipe_q [LATENCY];
  pipe_ent_t     pipe_d [LATENCY];

  logic          accept;
  logic          wr_en;
  logic          issue_vld;
  logic [15:0]   issue_addr;
  logic [15:0]   rd_data;
  logic          unused_bits;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    wr_en      = 1'b0;
    issue_vld  = 1'b0;
    issue_addr = 16'h0000;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        if (req_wr) begin
          wr_en = 1'b1;
        end else if (req_burst) begin
          base_d     = block_base(req_addr, BLOCK_WORDS);
          issue_vld  = 1'b1;
          issue_addr = base_d;
          cnt_d      = CW'(1);
          state_d    = ST_BURST;
        end else begin
          issue_vld  = 1'b1;
          issue_addr = {req_addr[15:1], 1'b0};
        end
      end
    end else begin
      // Offset stays inside the aligned block, so the sum never carries past it.
      issue_vld  = 1'b1;
      issue_addr = base_q + {{(15 - CW){1'b0}}, cnt_q, 1'b0};
      cnt_d      = cnt_q + CW'(1);
      if (cnt_q == CW'(BLOCK_WORDS - 1)) state_d = ST_IDLE;
    end
  end

  mem_word_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (req_addr[AW:1]),
    .wr_data (req_wdata),
    .rd_idx  (issue_addr[AW:1]),
    .rd_data (rd_data)
  );

  always_comb begin
    pipe_d[0] = '{valid: issue_vld, addr: issue_addr, data: (issue_vld ? rd_data : 16'h0000)};
    for (int i = 1; i < int'(LATENCY); i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      pipe_q  <= pipe_d;
    end
  end

  assign resp_valid  = pipe_q[LATENCY-1].valid;
  assign resp_addr   = pipe_q[LATENCY-1].addr;
  assign resp_data   = pipe_q[LATENCY-1].data;
  assign unused_bits = ^{req_addr[0], issue_addr[0]};

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: driver pushes expected responses, monitor checks them.
module tb_main_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr, req_burst;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [15:0] resp_data, resp_addr;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mdl [32768];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  main_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_burst  (req_burst),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented response must match the oldest expected entry.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp actual=addr %h data %h cycle %0d required=none",
                 resp_addr, resp_data, cyc);
      end else begin
        e = sb_q.pop_front();
        if (cyc != e.cyc || resp_addr !== e.addr || resp_data !== e.data) begin
          errors++;
          $display("FAIL resp actual=cyc %0d addr %h data %h required=cyc %0d addr %h data %h",
                   cyc, resp_addr, resp_data, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_burst = 1'b0;
  endtask

  task automatic idle(input int n);
    drive_idle();
    repeat (n) step();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic burst);
    req_valid = 1'b1; req_wr = 1'b1; req_burst = burst; req_addr = a; req_wdata = d;
    mdl[a[15:1]] = d;
    step();
    drive_idle();
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp_d);
    sb_q.push_back('{cyc: cyc + 4, addr: {a[15:1], 1'b0}, data: exp_d});
    req_valid = 1'b1; req_wr = 1'b0; req_burst = 1'b0; req_addr = a;
    step();
    drive_idle();
  endtask

  // Pushes n_exp responses (all 8 normally); optional poke drives a write while not ready.
  task automatic do_burst(input logic [15:0] a, input int n_exp, input logic poke);
    logic [15:0] base, wa;
    base = {a[15:4], 4'h0};
    for (int i = 0; i < n_exp; i++) begin
      wa = base + 16'(2 * i);
      sb_q.push_back('{cyc: cyc + 4 + i, addr: wa, data: mdl[wa[15:1]]});
    end
    req_valid = 1'b1; req_wr = 1'b0; req_burst = 1'b1; req_addr = a;
    step();
    drive_idle();
    if (n_exp == 8) begin
      for (int k = 1; k < 8; k++) begin
        if (poke) begin
          req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0300; req_wdata = 16'hDEAD;
        end
        chk("burst_ready_low", 32'(req_ready), 32'd0);
        step();
      end
      drive_idle();
      chk("burst_ready_back", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    int c0;
    rst = 1'b1; req_addr = 16'h0; req_wdata = 16'h0;
    drive_idle();
    for (int i = 0; i < 32768; i++) mdl[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_addr", 32'(resp_addr), 32'd0);
    rst = 1'b0;
    idle(8);

    // Write then read the same word on the next cycle: new data, latency 4.
    do_write(16'h0040, 16'h1234, 1'b0);
    do_read(16'h0040, 16'h1234);
    idle(6);

    // Preload a block and a few single words.
    for (int i = 0; i < 8; i++) do_write(16'h0100 + 16'(2 * i), 16'h00A0 + 16'(i), 1'b0);
    do_write(16'h0200, 16'h5555, 1'b0);
    do_write(16'h0300, 16'h0303, 1'b0);
    do_write(16'h0000, 16'hBEEF, 1'b0);
    for (int i = 0; i < 8; i++) do_write(16'hFFF0 + 16'(2 * i), 16'h7000 + 16'(i), 1'b0);
    idle(2);

    // Burst from a mid-block address returns the whole aligned block.
    do_burst(16'h0106, 8, 1'b0);
    idle(10);

    // Back-to-back single reads; odd address byte bit is ignored.
    chk("b2b_ready", 32'(req_ready), 32'd1);
    do_read(16'h0102, 16'h00A1);
    do_read(16'h0200, 16'h5555);
    do_read(16'h010F, 16'h00A7);
    do_read(16'h0040, 16'h1234);
    idle(6);

    // A read already in flight keeps its old data despite a following write.
    do_read(16'h0200, 16'h5555);
    do_write(16'h0200, 16'h6666, 1'b0);
    do_read(16'h0200, 16'h6666);
    idle(6);

    // Write with burst flag set is a plain single write with no response.
    do_write(16'h0042, 16'h4242, 1'b1);
    do_read(16'h0042, 16'h4242);
    idle(6);

    // Top block, plus writes offered while not ready must be ignored.
    do_burst(16'hFFF2, 8, 1'b1);
    idle(10);
    do_read(16'h0300, 16'h0303);
    do_read(16'h0000, 16'hBEEF);
    idle(6);

    // Reset mid-burst: only words issued before the reset edge come back.
    c0 = cyc;
    do_burst(16'h0100, 2, 1'b0);
    while (cyc < c0 + 5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    step();
    do_read(16'h0104, 16'h00A2);
    idle(12);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
